// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO unit: MTHI/MTLO commit on accept; MULT/MULTU commit 2 cycles after accept; DIV/DIVU commit 2 cycles after divider done.
// No queueing: op_valid is only sampled while busy=0, so the pipeline must stall HI/LO users while busy is high.
module mips_cpu_hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbz,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_done
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_START,
        S_DIV_WAIT,
        S_DIV_FIX
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dbz;
    logic        r_div_start;
    logic [31:0] r_div_dividend;
    logic [31:0] r_div_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_signed;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_rt_zero;
    logic        w_div_go;
    logic        w_div_signed;
    logic [31:0] w_rs_neg;
    logic [31:0] w_rt_neg;
    logic [63:0] w_mul_a64;
    logic [63:0] w_mul_b64;
    logic [63:0] w_product;
    logic [31:0] w_quot_neg;
    logic [31:0] w_rem_neg;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    assign w_accept     = op_valid && (r_state == S_IDLE);
    assign w_is_mul     = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign w_is_div     = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign w_rt_zero    = (rt_val == 32'd0);
    assign w_div_go     = w_accept && w_is_div && !w_rt_zero;
    assign w_div_signed = (op_code == OP_DIV);
    assign w_rs_neg     = ~rs_val + 32'd1;
    assign w_rt_neg     = ~rt_val + 32'd1;

    // Sign-extending into 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    assign w_mul_a64 = r_mul_signed ? {{32{r_mul_a[31]}}, r_mul_a} : {32'd0, r_mul_a};
    assign w_mul_b64 = r_mul_signed ? {{32{r_mul_b[31]}}, r_mul_b} : {32'd0, r_mul_b};
    assign w_product = w_mul_a64 * w_mul_b64;

    assign w_quot_neg = ~r_quot + 32'd1;
    assign w_rem_neg  = ~r_rem + 32'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                    end else if (w_is_div && !w_rt_zero) begin
                        w_state_nxt = S_DIV_START;
                    end else if (op_code == OP_MTHI) begin
                        w_hi_nxt = rs_val;
                    end else if (op_code == OP_MTLO) begin
                        w_lo_nxt = rs_val;
                    end
                end
            end
            S_MUL: begin
                w_hi_nxt    = w_product[63:32];
                w_lo_nxt    = w_product[31:0];
                w_state_nxt = S_IDLE;
            end
            S_DIV_START: begin
                // div_done here is still the level left over from the previous divide.
                w_state_nxt = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if (div_done) begin
                    w_state_nxt = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                w_lo_nxt    = r_neg_q ? w_quot_neg : r_quot;
                w_hi_nxt    = r_neg_r ? w_rem_neg : r_rem;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi           <= 32'd0;
            r_lo           <= 32'd0;
            r_dbz          <= 1'b0;
            r_div_start    <= 1'b0;
            r_div_dividend <= 32'd0;
            r_div_divisor  <= 32'd0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_quot         <= 32'd0;
            r_rem          <= 32'd0;
            r_mul_a        <= 32'd0;
            r_mul_b        <= 32'd0;
            r_mul_signed   <= 1'b0;
        end else begin
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_dbz       <= w_accept && w_is_div && w_rt_zero;
            r_div_start <= w_div_go;
            if (w_accept && w_is_mul) begin
                r_mul_a      <= rs_val;
                r_mul_b      <= rt_val;
                r_mul_signed <= (op_code == OP_MULT);
            end
            // Magnitudes stay on the divider ports until the next divide is accepted.
            if (w_div_go) begin
                r_div_dividend <= (w_div_signed && rs_val[31]) ? w_rs_neg : rs_val;
                r_div_divisor  <= (w_div_signed && rt_val[31]) ? w_rt_neg : rt_val;
                r_neg_q        <= w_div_signed && (rs_val[31] ^ rt_val[31]);
                r_neg_r        <= w_div_signed && rs_val[31];
            end
            if ((r_state == S_DIV_WAIT) && div_done) begin
                r_quot <= div_quotient;
                r_rem  <= div_remainder;
            end
        end
    end

    assign busy         = r_busy;
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign dbz          = r_dbz;
    assign div_start    = r_div_start;
    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Bench for mips_cpu_hilo_ctrl: driver pushes expected commits, a negedge monitor pops them on busy fall / dbz.
module tb_mips_cpu_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;

    always #5 clk = ~clk;

    mips_cpu_hilo_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_code       (op_code),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .busy          (busy),
        .hi            (hi),
        .lo            (lo),
        .dbz           (dbz),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done)
    );

    typedef struct {
        int          kind;   // 0 = MULT/DIV commit, 1 = divide-by-zero pulse
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] ma;
        logic [31:0] mb;
        int          blen;
        int          nst;
    } rec_t;

    rec_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;
    int          cur_lat  = 0;
    bit          hung     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Divider stand-in: result appears cur_lat cycles after start; done level persists until next start.
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_cnt;
    logic        m_pend;
    always @(posedge clk) begin
        if (reset) begin
            div_done      <= 1'b0;
            div_quotient  <= 32'd0;
            div_remainder <= 32'd0;
            m_pend        <= 1'b0;
            m_cnt         <= 0;
        end else if (div_start) begin
            if (div_dividend == 32'd0 || cur_lat == 0) begin
                div_done      <= 1'b1;
                div_quotient  <= div_dividend / div_divisor;
                div_remainder <= div_dividend % div_divisor;
                m_pend        <= 1'b0;
            end else begin
                div_done <= 1'b0;
                m_a      <= div_dividend;
                m_b      <= div_divisor;
                m_cnt    <= cur_lat;
                m_pend   <= 1'b1;
            end
        end else if (m_pend) begin
            if (m_cnt == 1) begin
                div_done      <= 1'b1;
                div_quotient  <= m_a / m_b;
                div_remainder <= m_a % m_b;
                m_pend        <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Monitor
    int m_blen = 0;
    int m_nst  = 0;
    bit m_pb   = 1'b0;
    always @(negedge clk) begin
        rec_t r;
        if (reset) begin
            m_blen = 0;
            m_nst  = 0;
            m_pb   = 1'b0;
        end else begin
            if (busy === 1'b1) m_blen++;
            if (div_start === 1'b1) begin
                m_nst++;
                if (sbq.size() > 0 && sbq[0].kind == 0 && sbq[0].nst == 1) begin
                    chk("div_dividend", div_dividend, sbq[0].ma);
                    chk("div_divisor", div_divisor, sbq[0].mb);
                end
            end
            if (dbz === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dbz_unexpected actual=1 required=0");
                end else begin
                    r = sbq.pop_front();
                    chk("dbz_event_kind", r.kind, 1);
                    chk("dbz_hi", hi, r.hi);
                    chk("dbz_lo", lo, r.lo);
                    chk("dbz_busy", busy, 0);
                    chk("dbz_div_start_count", m_nst, 0);
                end
                m_nst = 0;
            end
            if (m_pb && busy === 1'b0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL commit_unexpected actual=busy_fall required=none");
                end else begin
                    r = sbq.pop_front();
                    chk("commit_kind", r.kind, 0);
                    chk("commit_hi", hi, r.hi);
                    chk("commit_lo", lo, r.lo);
                    chk("busy_cycles", m_blen, r.blen);
                    chk("div_start_count", m_nst, r.nst);
                end
                m_blen = 0;
                m_nst  = 0;
            end
            m_pb = (busy === 1'b1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && !hung) begin
            if (n >= 200) begin
                checks++;
                failures++;
                $display("FAIL wait_idle busy=%b required=0", busy);
                hung = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int lat, input bit junk);
        rec_t        r;
        longint      sa, sb, sq, sr, mag;
        logic [63:0] up;
        bit          md;
        md = 1'b0;
        @(negedge clk);
        wait_idle();
        if (hung) return;
        cur_lat  = lat;
        op_valid = 1'b1;
        op_code  = op;
        rs_val   = rs;
        rt_val   = rt;
        r.kind = 0; r.hi = exp_hi; r.lo = exp_lo; r.ma = 32'd0; r.mb = 32'd0; r.blen = 0; r.nst = 0;
        case (op)
            3'd0: begin
                sa = longint'($signed(rs));
                sb = longint'($signed(rt));
                up = sa * sb;
                exp_hi = up[63:32]; exp_lo = up[31:0];
                md = 1'b1; r.blen = 1;
            end
            3'd1: begin
                up = {32'd0, rs} * {32'd0, rt};
                exp_hi = up[63:32]; exp_lo = up[31:0];
                md = 1'b1; r.blen = 1;
            end
            3'd2, 3'd3: begin
                if (rt == 32'd0) begin
                    r.kind = 1;
                end else begin
                    if (op == 3'd2) begin
                        sa = longint'($signed(rs));
                        sb = longint'($signed(rt));
                        sq = sa / sb;
                        sr = sa % sb;
                        up = sq; exp_lo = up[31:0];
                        up = sr; exp_hi = up[31:0];
                        mag = (sa < 0) ? -sa : sa; up = mag; r.ma = up[31:0];
                        mag = (sb < 0) ? -sb : sb; up = mag; r.mb = up[31:0];
                    end else begin
                        exp_lo = rs / rt;
                        exp_hi = rs % rt;
                        r.ma = rs;
                        r.mb = rt;
                    end
                    md = 1'b1; r.nst = 1;
                    r.blen = 3 + ((rs == 32'd0) ? 0 : lat);
                end
            end
            3'd4: exp_hi = rs;
            3'd5: exp_lo = rs;
            default: ;
        endcase
        if (md) begin
            r.hi = exp_hi;
            r.lo = exp_lo;
        end
        if (md || r.kind == 1) sbq.push_back(r);
        @(posedge clk);
        #1;
        if (junk && md) begin
            // Offered while busy: must be ignored entirely.
            op_code = 3'($urandom_range(0, 5));
            rs_val  = $urandom;
            rt_val  = $urandom;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        if (!md && r.kind == 0) begin
            @(negedge clk);
            chk("hi_after_move", hi, exp_hi);
            chk("lo_after_move", lo, exp_lo);
        end
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = 32'($urandom_range(0, 20));
            1: v = $urandom;
            2: v = 32'd0 - 32'($urandom_range(1, 20));
            default: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h8000_0000;
                    1: v = 32'hFFFF_FFFF;
                    2: v = 32'h0000_0000;
                    default: v = 32'h7FFF_FFFF;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_dbz", dbz, 0);
        chk("reset_div_start", div_start, 0);
        chk("reset_div_dividend", div_dividend, 0);
        chk("reset_div_divisor", div_divisor, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b1);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        issue(3'd3, 32'd100, 32'd7, 4, 1'b1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 2, 1'b0);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0);
        issue(3'd2, 32'd0, 32'd5, 5, 1'b0);
        issue(3'd4, 32'hA5A5_A5A5, 32'd0, 0, 1'b0);
        issue(3'd3, 32'd9, 32'd0, 0, 1'b0);

        // Reset while the divider is still working.
        issue(3'd3, 32'd1000, 32'd7, 20, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        chk("midreset_busy", busy, 0);
        chk("midreset_hi", hi, 0);
        chk("midreset_lo", lo, 0);
        chk("midreset_div_start", div_start, 0);
        issue(3'd3, 32'd10, 32'd3, 1, 1'b0);

        for (int i = 0; i < 150 && !hung; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_val();
            b  = rand_val();
            if ((op == 3'd2 || op == 3'd3) && $urandom_range(0, 5) == 0) b = 32'd0;
            issue(op, a, b, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
